// File: rtl/saturn_bus_arbiter.sv
// saturn_bus_arbiter
//   Arbitrates a shared nibble bus between two requesters: 0 = control unit,
//   1 = debugger. A bus cycle is four one-hot phases (0001 drive, 0010 sample,
//   0100 settle, 1000 idle). At drive the owner (or the winner of a
//   round-robin tie in IDLE, with zero latency) issues one slot. Ownership
//   lasts until a slot flagged "last" completes at settle.
//
// Ports
//   i_clk, i_reset              clock; asynchronous active-high reset
//   i_phases[3:0]               one-hot bus phase
//   i_req_n / i_item_n[4:0]     per-requester slot: item[4] = command flag,
//   i_rd_n / i_last_n           item[3:0] = nibble, rd = read slot, last = burst end
//   o_ack_n                     one-clock pulse: slot consumed
//   o_rd_valid_n, o_rd_nibble   read data returned to requester n
//   i_bus_nibble_in             nibble sampled from the bus at phase 0010
//   o_bus_nibble_out,
//   o_bus_is_data, o_bus_clk_en bus drive side
//   o_grant[1:0]                one-hot owner, 00 when idle
//   o_error                     sticky fault (bad phase encoding, timeout)
//
// Configuration
//   SATURN_BUS_ARB_TIMEOUT_EN   when defined, an owner that issues no slot for
//                               15 consecutive bus cycles is released and
//                               o_error is set. Undefined: ownership is held
//                               until the owner's last slot.

module saturn_bus_arbiter (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_phases,
  input  logic       i_req_0,
  input  logic [4:0] i_item_0,
  input  logic       i_rd_0,
  input  logic       i_last_0,
  input  logic       i_req_1,
  input  logic [4:0] i_item_1,
  input  logic       i_rd_1,
  input  logic       i_last_1,
  output logic       o_ack_0,
  output logic       o_ack_1,
  output logic       o_rd_valid_0,
  output logic       o_rd_valid_1,
  output logic [3:0] o_rd_nibble,
  input  logic [3:0] i_bus_nibble_in,
  output logic [3:0] o_bus_nibble_out,
  output logic       o_bus_is_data,
  output logic       o_bus_clk_en,
  output logic [1:0] o_grant,
  output logic       o_error
);

  localparam logic [3:0] PH_DRIVE  = 4'b0001;
  localparam logic [3:0] PH_SAMPLE = 4'b0010;
  localparam logic [3:0] PH_SETTLE = 4'b0100;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [1:0] ack_q, ack_d;
  logic [1:0] rd_valid_q, rd_valid_d;
  logic       clk_en_q, clk_en_d;
  logic [3:0] nib_out_q, nib_out_d;
  logic       is_data_q, is_data_d;
  logic [3:0] rd_nib_q, rd_nib_d;
  logic       err_q, err_d;
  logic       pref_q, pref_d;            // requester favoured on a tie
  // Slot issued at this bus cycle's drive phase; consumed at sample/settle.
  logic       slot_issued_q, slot_issued_d;
  logic       slot_rd_q, slot_rd_d;
  logic       slot_last_q, slot_last_d;
  logic       slot_who_q, slot_who_d;
`ifdef SATURN_BUS_ARB_TIMEOUT_EN
  logic [3:0] idle_cnt_q, idle_cnt_d;    // consecutive owner cycles without a slot
`endif

  logic             issue;
  logic             sel;
  logic [1:0]       req_v, rd_v, last_v;
  logic [1:0][4:0]  item_v;
  logic             phase_onehot;

  assign req_v  = {i_req_1, i_req_0};
  assign rd_v   = {i_rd_1, i_rd_0};
  assign last_v = {i_last_1, i_last_0};
  assign item_v = {i_item_1, i_item_0};

  // x & (x-1) clears the lowest set bit: zero only for a single set bit.
  assign phase_onehot = (i_phases != 4'b0000) &&
                        ((i_phases & (i_phases - 4'd1)) == 4'b0000);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    ack_d         = 2'b00;
    rd_valid_d    = 2'b00;
    clk_en_d      = clk_en_q;
    nib_out_d     = nib_out_q;
    is_data_d     = is_data_q;
    rd_nib_d      = rd_nib_q;
    err_d         = err_q;
    pref_d        = pref_q;
    slot_issued_d = slot_issued_q;
    slot_rd_d     = slot_rd_q;
    slot_last_d   = slot_last_q;
    slot_who_d    = slot_who_q;
    issue         = 1'b0;
    sel           = 1'b0;
`ifdef SATURN_BUS_ARB_TIMEOUT_EN
    idle_cnt_d    = idle_cnt_q;
`endif

    if (!phase_onehot) begin
      err_d = 1'b1;
    end else begin
      case (i_phases)
        PH_DRIVE: begin
          slot_issued_d = 1'b0;
          case (state_q)
            IDLE: begin
              if (req_v != 2'b00) begin
                sel     = (req_v == 2'b11) ? pref_q : req_v[1];
                issue   = 1'b1;
                state_d = sel ? OWN1 : OWN0;
                pref_d  = ~sel;
`ifdef SATURN_BUS_ARB_TIMEOUT_EN
                idle_cnt_d = 4'd0;
`endif
              end
            end
            OWN0, OWN1: begin
              sel   = (state_q == OWN1);
              issue = req_v[sel];
`ifdef SATURN_BUS_ARB_TIMEOUT_EN
              if (issue) begin
                idle_cnt_d = 4'd0;
              end else begin
                idle_cnt_d = idle_cnt_q + 4'd1;
                if (idle_cnt_d == 4'd15) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
                end
              end
`endif
            end
            default: state_d = IDLE;
          endcase

          if (issue) begin
            ack_d[sel]    = 1'b1;
            clk_en_d      = 1'b1;
            slot_issued_d = 1'b1;
            slot_rd_d     = rd_v[sel];
            slot_last_d   = last_v[sel];
            slot_who_d    = sel;
            // Read slots leave the bus drive outputs untouched.
            if (!rd_v[sel]) begin
              nib_out_d = item_v[sel][3:0];
              is_data_d = ~item_v[sel][4];
            end
          end
        end
        PH_SAMPLE: begin
          clk_en_d = 1'b0;
          if (slot_issued_q && slot_rd_q) begin
            rd_nib_d               = i_bus_nibble_in;
            rd_valid_d[slot_who_q] = 1'b1;
          end
        end
        PH_SETTLE: begin
          if (slot_issued_q && slot_last_q) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      ack_q         <= 2'b00;
      rd_valid_q    <= 2'b00;
      clk_en_q      <= 1'b0;
      nib_out_q     <= 4'd0;
      is_data_q     <= 1'b0;
      rd_nib_q      <= 4'd0;
      err_q         <= 1'b0;
      pref_q        <= 1'b0;
      slot_issued_q <= 1'b0;
      slot_rd_q     <= 1'b0;
      slot_last_q   <= 1'b0;
      slot_who_q    <= 1'b0;
`ifdef SATURN_BUS_ARB_TIMEOUT_EN
      idle_cnt_q    <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      rd_valid_q    <= rd_valid_d;
      clk_en_q      <= clk_en_d;
      nib_out_q     <= nib_out_d;
      is_data_q     <= is_data_d;
      rd_nib_q      <= rd_nib_d;
      err_q         <= err_d;
      pref_q        <= pref_d;
      slot_issued_q <= slot_issued_d;
      slot_rd_q     <= slot_rd_d;
      slot_last_q   <= slot_last_d;
      slot_who_q    <= slot_who_d;
`ifdef SATURN_BUS_ARB_TIMEOUT_EN
      idle_cnt_q    <= idle_cnt_d;
`endif
    end
  end

  assign o_ack_0          = ack_q[0];
  assign o_ack_1          = ack_q[1];
  assign o_rd_valid_0     = rd_valid_q[0];
  assign o_rd_valid_1     = rd_valid_q[1];
  assign o_rd_nibble      = rd_nib_q;
  assign o_bus_nibble_out = nib_out_q;
  assign o_bus_is_data    = is_data_q;
  assign o_bus_clk_en     = clk_en_q;
  assign o_grant          = {state_q == OWN1, state_q == OWN0};
  assign o_error          = err_q;

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Testbench for saturn_bus_arbiter. Each requester has a queue of slots
// (item, rd, last, gap before presenting). A per-bus-cycle reference model
// decides the owner and which slot is consumed, and pushes the expected
// ack / read-data events onto a scoreboard that a negedge monitor drains.

module tb_saturn_bus_arbiter;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_phases;
  logic       i_req_0, i_rd_0, i_last_0;
  logic [4:0] i_item_0;
  logic       i_req_1, i_rd_1, i_last_1;
  logic [4:0] i_item_1;
  logic [3:0] i_bus_nibble_in;
  logic       o_ack_0, o_ack_1, o_rd_valid_0, o_rd_valid_1;
  logic [3:0] o_rd_nibble, o_bus_nibble_out;
  logic       o_bus_is_data, o_bus_clk_en, o_error;
  logic [1:0] o_grant;

  saturn_bus_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_phases(i_phases),
    .i_req_0(i_req_0), .i_item_0(i_item_0), .i_rd_0(i_rd_0), .i_last_0(i_last_0),
    .i_req_1(i_req_1), .i_item_1(i_item_1), .i_rd_1(i_rd_1), .i_last_1(i_last_1),
    .o_ack_0(o_ack_0), .o_ack_1(o_ack_1),
    .o_rd_valid_0(o_rd_valid_0), .o_rd_valid_1(o_rd_valid_1),
    .o_rd_nibble(o_rd_nibble), .i_bus_nibble_in(i_bus_nibble_in),
    .o_bus_nibble_out(o_bus_nibble_out), .o_bus_is_data(o_bus_is_data),
    .o_bus_clk_en(o_bus_clk_en), .o_grant(o_grant), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4:0] item;
    bit         rd;
    bit         last;
    int         gap;
  } slot_t;

  typedef struct {
    bit         is_rd;
    bit         who;
    logic [3:0] nib;
    bit         is_data;
    logic [1:0] grant;
  } exp_t;

  slot_t sq0[$];
  slot_t sq1[$];
  exp_t  expq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_owner  = -1;
  bit         m_pref   = 1'b0;
  logic [3:0] m_nib    = 4'd0;
  bit         m_isdata = 1'b0;
  bit         m_err    = 1'b0;
  int         m_idle   = 0;
  int         hold0    = 0;
  int         hold1    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_slot(input int n, input logic [4:0] item, input bit rd,
                           input bit last, input int gap);
    slot_t s;
    s.item = item; s.rd = rd; s.last = last; s.gap = gap;
    if (n == 0) begin
      if (sq0.size() == 0) hold0 = gap;
      sq0.push_back(s);
    end else begin
      if (sq1.size() == 0) hold1 = gap;
      sq1.push_back(s);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_pref = 1'b0; m_nib = 4'd0; m_isdata = 1'b0;
    m_err = 1'b0; m_idle = 0; hold0 = 0; hold1 = 0;
    sq0.delete(); sq1.delete(); expq.delete();
  endtask

  // One full bus cycle (four phases). With rst_mid, reset is asserted during
  // the sample phase and the cycle is abandoned.
  task automatic bus_cycle(input logic [3:0] bnib, input bit rst_mid);
    bit    r0, r1, issued, s_rd, s_last;
    int    who;
    slot_t s;
    exp_t  e;
    r0 = (sq0.size() > 0) && (hold0 == 0);
    r1 = (sq1.size() > 0) && (hold1 == 0);
    i_req_0  = r0;
    i_item_0 = r0 ? sq0[0].item : 5'($urandom);
    i_rd_0   = r0 ? sq0[0].rd   : 1'($urandom);
    i_last_0 = r0 ? sq0[0].last : 1'($urandom);
    i_req_1  = r1;
    i_item_1 = r1 ? sq1[0].item : 5'($urandom);
    i_rd_1   = r1 ? sq1[0].rd   : 1'($urandom);
    i_last_1 = r1 ? sq1[0].last : 1'($urandom);
    if (!r0 && sq0.size() > 0 && hold0 > 0) hold0--;
    if (!r1 && sq1.size() > 0 && hold1 > 0) hold1--;

    who = -1; issued = 1'b0; s_rd = 1'b0; s_last = 1'b0;
    if (m_owner < 0) begin
      if (r0 && r1)  who = m_pref ? 1 : 0;
      else if (r0)   who = 0;
      else if (r1)   who = 1;
      if (who >= 0) begin
        m_owner = who;
        m_pref  = (who == 0);
        m_idle  = 0;
      end
    end else if ((m_owner == 0 && r0) || (m_owner == 1 && r1)) begin
      who = m_owner;
    end else begin
`ifdef SATURN_BUS_ARB_TIMEOUT_EN
      m_idle++;
      if (m_idle == 15) begin
        m_owner = -1;
        m_err   = 1'b1;
      end
`endif
    end

    if (who >= 0) begin
      if (who == 0) begin
        s = sq0.pop_front();
        if (sq0.size() > 0) hold0 = sq0[0].gap;
      end else begin
        s = sq1.pop_front();
        if (sq1.size() > 0) hold1 = sq1[0].gap;
      end
      m_idle = 0;
      if (!s.rd) begin
        m_nib    = s.item[3:0];
        m_isdata = !s.item[4];
      end
      e.is_rd = 1'b0; e.who = (who == 1); e.nib = m_nib;
      e.is_data = m_isdata; e.grant = (who == 1) ? 2'b10 : 2'b01;
      expq.push_back(e);
      issued = 1'b1; s_rd = s.rd; s_last = s.last;
    end

    i_phases = 4'b0001;
    @(posedge i_clk); #1;
    i_phases = 4'b0010;
    i_bus_nibble_in = bnib;
    if (issued && s_rd) begin
      e.is_rd = 1'b1; e.who = (who == 1); e.nib = bnib;
      e.is_data = 1'b0; e.grant = (who == 1) ? 2'b10 : 2'b01;
      expq.push_back(e);
    end
    if (rst_mid) begin
      @(negedge i_clk); #1;
      i_reset = 1'b1;
      #1;
      check("reset_mid_outputs",
            {o_ack_0, o_ack_1, o_rd_valid_0, o_rd_valid_1, o_rd_nibble,
             o_bus_nibble_out, o_bus_is_data, o_bus_clk_en, o_error}, 0);
      check("reset_mid_grant", o_grant, 0);
      model_reset();
      i_req_0 = 1'b0; i_req_1 = 1'b0;
      @(posedge i_clk); #1;
      i_phases = 4'b1000;
      i_reset  = 1'b0;
      return;
    end
    @(posedge i_clk); #1;
    check("clk_en_low_after_sample", o_bus_clk_en, 0);
    i_phases = 4'b0100;
    @(posedge i_clk); #1;
    if (issued && s_last) m_owner = -1;
    i_phases = 4'b1000;
    @(posedge i_clk); #1;
    check("grant_end_of_cycle", o_grant, (m_owner < 0) ? 0 : ((m_owner == 1) ? 2 : 1));
    check("error_flag", o_error, m_err);
  endtask

  // Monitor: every ack / rd_valid pulse must match the next expected event.
  always @(negedge i_clk) begin
    exp_t me;
    if (!i_reset && (o_ack_0 || o_ack_1 || o_rd_valid_0 || o_rd_valid_1)) begin
      check("ack_exclusive_grant_legal", {o_ack_0 & o_ack_1, o_grant == 2'b11}, 0);
      if (expq.size() == 0) begin
        check("unexpected_output", {o_ack_1, o_ack_0, o_rd_valid_1, o_rd_valid_0}, 0);
      end else begin
        me = expq.pop_front();
        if (!me.is_rd)
          check("ack_slot",
                {o_ack_1, o_ack_0, o_rd_valid_1, o_rd_valid_0, o_bus_clk_en,
                 o_bus_is_data, o_bus_nibble_out, o_grant},
                {me.who, !me.who, 2'b00, 1'b1, me.is_data, me.nib, me.grant});
        else
          check("rd_slot",
                {o_rd_valid_1, o_rd_valid_0, o_ack_1, o_ack_0, o_rd_nibble},
                {me.who, !me.who, 2'b00, me.nib});
      end
    end
  end

  initial begin
    int len;
    int budget;
    i_reset = 1'b1; i_phases = 4'b1000; i_bus_nibble_in = 4'd0;
    i_req_0 = 1'b0; i_item_0 = 5'd0; i_rd_0 = 1'b0; i_last_0 = 1'b0;
    i_req_1 = 1'b0; i_item_1 = 5'd0; i_rd_1 = 1'b0; i_last_1 = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_state",
          {o_ack_0, o_ack_1, o_rd_valid_0, o_rd_valid_1, o_rd_nibble,
           o_bus_nibble_out, o_bus_is_data, o_bus_clk_en, o_grant, o_error}, 0);
    i_reset = 1'b0;

    // Contention from reset: 0 then 1, twice.
    repeat (2) begin
      push_slot(0, 5'h03, 1'b0, 1'b1, 0);
      push_slot(1, 5'h1C, 1'b0, 1'b1, 0);
      repeat (2) bus_cycle(4'($urandom), 1'b0);
    end

    // Single command write: nibble 5, is_data 0.
    push_slot(0, 5'b10101, 1'b0, 1'b1, 0);
    bus_cycle(4'($urandom), 1'b0);

    // Burst lock: requester 1 three slots, requester 0 arrives one cycle later.
    push_slot(1, 5'h01, 1'b0, 1'b0, 0);
    push_slot(1, 5'h12, 1'b0, 1'b0, 0);
    push_slot(1, 5'h0F, 1'b0, 1'b1, 0);
    push_slot(0, 5'h17, 1'b0, 1'b1, 1);
    repeat (4) bus_cycle(4'($urandom), 1'b0);

    // Read by requester 1 with bus nibble A.
    push_slot(1, 5'($urandom), 1'b1, 1'b1, 0);
    bus_cycle(4'hA, 1'b0);

    // Owner stalls mid-burst for 20 cycles while requester 1 waits.
    push_slot(0, 5'h06, 1'b0, 1'b0, 0);
    push_slot(0, 5'h19, 1'b0, 1'b1, 20);
    push_slot(1, 5'h0B, 1'b0, 1'b1, 1);
    repeat (25) bus_cycle(4'($urandom), 1'b0);

    // Non-one-hot phase during ownership: error set, grant unchanged.
    push_slot(0, 5'h02, 1'b0, 1'b0, 0);
    push_slot(0, 5'h1E, 1'b0, 1'b1, 0);
    bus_cycle(4'($urandom), 1'b0);
    i_phases = 4'b0110;
    @(posedge i_clk); #1;
    m_err = 1'b1;
    check("bad_phase_error", o_error, m_err);
    check("bad_phase_grant_held", o_grant, 2'b01);
    bus_cycle(4'($urandom), 1'b0);

    // Randomized bursts from both requesters.
    for (int n = 0; n < 2; n++) begin
      for (int b = 0; b < 8; b++) begin
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++)
          push_slot(n, 5'($urandom), ($urandom_range(0, 3) == 0), (k == len - 1),
                    $urandom_range(0, 3));
      end
    end
    budget = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || m_owner >= 0) && budget < 400) begin
      bus_cycle(4'($urandom), 1'b0);
      budget++;
    end
    check("random_drained", sq0.size() + sq1.size(), 0);

    // Reset during the sample phase of the second slot of a burst.
    push_slot(0, 5'h11, 1'b0, 1'b0, 0);
    push_slot(0, 5'h04, 1'b0, 1'b0, 0);
    push_slot(0, 5'h1A, 1'b0, 1'b1, 0);
    bus_cycle(4'($urandom), 1'b0);
    bus_cycle(4'($urandom), 1'b1);

    // First grant after reset, tie goes to requester 0.
    push_slot(1, 5'h0C, 1'b0, 1'b1, 0);
    push_slot(0, 5'h18, 1'b0, 1'b1, 0);
    repeat (4) bus_cycle(4'($urandom), 1'b0);

    check("scoreboard_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
